// File: rtl/pipe_mux_reg_if.sv
// pipe_mux_reg_if: operand-select bus between a pipeline stage and the select register
interface pipe_mux_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 8
);
    logic                    en;
    logic                    clr;
    logic                    valid_in;
    logic [SEL_W-1:0]        select;
    logic [NUM_IN*WIDTH-1:0] d_flat;
    logic [WIDTH-1:0]        y_q;
    logic                    valid_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    sel_err;
    logic [CNT_W-1:0]        err_count;

    modport master (
        output en, clr, valid_in, select, d_flat,
        input  y_q, valid_q, sel_q, sel_err, err_count
    );

    modport slave (
        input  en, clr, valid_in, select, d_flat,
        output y_q, valid_q, sel_q, sel_err, err_count
    );
endinterface

// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: N-input operand mux into a stall/flush pipeline register with illegal-select tracking
module pipe_mux_reg #(
    parameter int WIDTH        = 32,
    parameter int NUM_IN       = 3,
    parameter int SEL_W        = $clog2(NUM_IN),
    parameter int ILLEGAL_HOLD = 0,
    parameter int CNT_W        = 8
) (
    input logic          clk,
    input logic          reset,
    pipe_mux_reg_if.slave bus
);
    localparam int SLOTS = 2 ** SEL_W;

    logic [WIDTH-1:0] opt [SLOTS];
    logic [SLOTS-1:0] legal_map;
    logic             legal;
    logic             cap;

    // Every select code maps to a defined value; codes past NUM_IN read as zero and are flagged illegal
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < NUM_IN) begin : g_in
            assign opt[g]       = bus.d_flat[g*WIDTH +: WIDTH];
            assign legal_map[g] = 1'b1;
        end else begin : g_out
            assign opt[g]       = '0;
            assign legal_map[g] = 1'b0;
        end
    end

    assign legal = legal_map[bus.select];
    assign cap   = bus.en & ~bus.clr & bus.valid_in & ~legal;

    // Data path register: flush beats enable, illegal selects follow the hold/zero policy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.y_q     <= '0;
            bus.valid_q <= 1'b0;
            bus.sel_q   <= '0;
        end else if (bus.clr) begin
            bus.y_q     <= '0;
            bus.valid_q <= 1'b0;
            bus.sel_q   <= '0;
        end else if (bus.en) begin
            bus.valid_q <= bus.valid_in;
            bus.sel_q   <= bus.select;
            if (legal)
                bus.y_q <= opt[bus.select];
            else if (ILLEGAL_HOLD == 0)
                bus.y_q <= '0;
        end
    end

    // Sticky error and saturating counter, only real (valid) illegal captures count; flush leaves them alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sel_err   <= 1'b0;
            bus.err_count <= '0;
        end else if (cap) begin
            bus.sel_err   <= 1'b1;
            bus.err_count <= (bus.err_count == '1) ? bus.err_count : bus.err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb_pipe_mux_reg: scoreboard bench over three configurations (zero policy, hold policy with 2-bit counter, power-of-two inputs)
module tb_pipe_mux_reg;
    typedef struct packed {
        logic [31:0] y;
        logic        v;
        logic [1:0]  s;
        logic        e;
        logic [7:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  sel = '0;
    logic [31:0] dv [4];

    int n_checks = 0;
    int n_fail = 0;
    int ni [3];
    int hold [3];
    int cmax [3];
    exp_t m [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;

    pipe_mux_reg_if #(.WIDTH(32), .NUM_IN(3), .CNT_W(8)) ia ();
    pipe_mux_reg_if #(.WIDTH(32), .NUM_IN(3), .CNT_W(2)) ib ();
    pipe_mux_reg_if #(.WIDTH(32), .NUM_IN(4), .CNT_W(8)) ic ();

    assign ia.en = en;  assign ib.en = en;  assign ic.en = en;
    assign ia.clr = clr;  assign ib.clr = clr;  assign ic.clr = clr;
    assign ia.valid_in = valid_in;  assign ib.valid_in = valid_in;  assign ic.valid_in = valid_in;
    assign ia.select = sel;  assign ib.select = sel;  assign ic.select = sel;
    assign ia.d_flat = {dv[2], dv[1], dv[0]};
    assign ib.d_flat = {dv[2], dv[1], dv[0]};
    assign ic.d_flat = {dv[3], dv[2], dv[1], dv[0]};

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .ILLEGAL_HOLD(0), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .ILLEGAL_HOLD(1), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    pipe_mux_reg #(.WIDTH(32), .NUM_IN(4), .ILLEGAL_HOLD(0), .CNT_W(8)) dut_c (.clk(clk), .reset(reset), .bus(ic));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t obs(input int k);
        exp_t o;
        if (k == 0)      o = '{ia.y_q, ia.valid_q, ia.sel_q, ia.sel_err, ia.err_count};
        else if (k == 1) o = '{ib.y_q, ib.valid_q, ib.sel_q, ib.sel_err, {6'b0, ib.err_count}};
        else             o = '{ic.y_q, ic.valid_q, ic.sel_q, ic.sel_err, ic.err_count};
        return o;
    endfunction

    task automatic compare(input string tag, input int k, input exp_t x);
        exp_t o;
        o = obs(k);
        check($sformatf("%s.y%0d", tag, k), o.y, x.y);
        check($sformatf("%s.valid%0d", tag, k), {31'b0, o.v}, {31'b0, x.v});
        check($sformatf("%s.sel%0d", tag, k), {30'b0, o.s}, {30'b0, x.s});
        check($sformatf("%s.err%0d", tag, k), {31'b0, o.e}, {31'b0, x.e});
        check($sformatf("%s.cnt%0d", tag, k), {24'b0, o.c}, {24'b0, x.c});
    endtask

    task automatic predict(input int k);
        exp_t n;
        logic ok;
        n = m[k];
        ok = int'(sel) < ni[k];
        if (clr) begin
            n.y = '0;
            n.v = 1'b0;
            n.s = '0;
        end else if (en) begin
            n.v = valid_in;
            n.s = sel;
            n.y = ok ? dv[sel] : (hold[k] != 0 ? m[k].y : 32'h0);
            if (valid_in && !ok) begin
                n.e = 1'b1;
                n.c = (int'(m[k].c) == cmax[k]) ? m[k].c : m[k].c + 8'd1;
            end
        end
        m[k] = n;
        if (k == 0) q0.push_back(n);
        else if (k == 1) q1.push_back(n);
        else q2.push_back(n);
    endtask

    task automatic step(input string tag, input logic e, input logic c, input logic vi, input logic [1:0] s);
        exp_t x;
        en = e; clr = c; valid_in = vi; sel = s;
        for (int k = 0; k < 3; k++) predict(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0) || (k == 2 && q2.size() == 0)) begin
                check($sformatf("%s.empty%0d", tag, k), 32'd0, 32'd1);
            end else begin
                if (k == 0) x = q0.pop_front();
                else if (k == 1) x = q1.pop_front();
                else x = q2.pop_front();
                compare(tag, k, x);
            end
        end
    endtask

    initial begin
        ni = '{3, 3, 4};
        hold = '{0, 1, 0};
        cmax = '{255, 3, 255};
        dv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int k = 0; k < 3; k++) m[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) compare("reset", k, m[k]);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("sel0", 1, 0, 1, 2'd0);
        step("sel1", 1, 0, 1, 2'd1);
        step("sel2", 1, 0, 1, 2'd2);
        step("ill3", 1, 0, 1, 2'd3);
        step("after", 1, 0, 1, 2'd1);
        step("cap2", 1, 0, 1, 2'd2);
        step("ill3b", 1, 0, 1, 2'd3);
        step("bub3", 1, 0, 0, 2'd3);
        step("cap1", 1, 0, 1, 2'd1);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 1, 2'd2);
        step("flush", 0, 1, 1, 2'd2);
        step("flushen", 1, 1, 1, 2'd3);
        for (int i = 0; i < 5; i++) step("sat", 1, 0, 1, 2'd3);
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) dv[j] = $urandom;
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        dv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        step("pre", 1, 0, 1, 2'd2);
        step("pre_err", 1, 0, 1, 2'd3);
        step("pre_y", 1, 0, 1, 2'd2);
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) m[k] = '0;
        for (int k = 0; k < 3; k++) compare("async", k, m[k]);
        @(negedge clk);
        reset = 1'b0;
        #1;
        step("resume", 1, 0, 1, 2'd1);
        step("resume2", 1, 0, 1, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
